// File: rtl/fifo_rd_arb_pkg.sv
// fifo_rd_arb_pkg: shared types and widths for the FIFO read-port arbiter.
// Contents: FSM state enum, beat counter width, watchdog stall counter width.
// Imported by fifo_rd_arbiter and rr_pick.
package fifo_rd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Beat counter covers BURST_MAX up to 16.
  localparam int BEAT_W  = 5;
  // Stall counter covers STALL_MAX up to 255 (watchdog build only).
  localparam int STALL_W = 8;

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// fifo_rd_arbiter_if: FIFO read-port and consumer-side signals of the arbiter.
// Ports: rd_empty/rd_data/rd_ena to the read pointer block; req/gnt/out_data/out_valid to consumers.
// master = arbiter side, slave = FIFO plus consumers side.
interface fifo_rd_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic                  rd_empty;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_ena;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    gnt;
  logic [DATA_WIDTH-1:0] out_data;
  logic [NUM_REQ-1:0]    out_valid;

  modport master (
    input  rd_empty, rd_data, req,
    output rd_ena, gnt, out_data, out_valid
  );

  modport slave (
    output rd_empty, rd_data, req,
    input  rd_ena, gnt, out_data, out_valid
  );
endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, lowest index strictly after i_last (wrapping).
// Ports: i_req request vector, i_last last-served index; o_idx chosen index, o_vld any request.
// Zero latency; no state.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_last,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_vld
);
  localparam int IW = $clog2(NUM_REQ);

  int w_best_d;
  int w_d;

  // Distance 0 is the slot right after i_last; the smallest distance with a request wins.
  always_comb begin
    o_idx    = '0;
    o_vld    = 1'b0;
    w_best_d = NUM_REQ;
    w_d      = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_d = (j + NUM_REQ - 1 - int'(i_last)) % NUM_REQ;
      if (i_req[j] && (w_d < w_best_d)) begin
        w_best_d = w_d;
        o_idx    = IW'(j);
        o_vld    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin burst arbiter sharing one FIFO read port among NUM_REQ consumers.
// Ports: rd_clk, rd_rst (async active-high), bus (fifo_rd_arbiter_if.master). Pop-to-out_valid latency 1 cycle.
// Optional FIFO_RD_ARB_WDOG_EN: releases a grant after STALL_MAX consecutive empty stalls.
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int ADDR_SIZE  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_MAX  = 4,
  parameter int STALL_MAX  = 8
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  fifo_rd_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);

  // ADDR_SIZE only mirrors the read pointer block; it is range-checked here, nothing else.
  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (BURST_MAX < 1) || (BURST_MAX > 16) ||
      (STALL_MAX < 1) || (STALL_MAX > 255) || (ADDR_SIZE < 1)) begin : g_param_check
    $error("fifo_rd_arbiter: parameter out of range");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IW-1:0]         r_grant;
  logic [IW-1:0]         r_last;
  logic [BEAT_W-1:0]     r_beat;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [NUM_REQ-1:0]    r_out_valid;
  logic [IW-1:0]         w_pick_idx;
  logic                  w_pick_vld;
  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic                  w_req_g;
  logic                  w_pop;
  logic                  w_last_beat;
  logic                  w_wdog;
  logic                  w_end;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_idx  (w_pick_idx),
    .o_vld  (w_pick_vld)
  );

  assign w_gnt_oh    = NUM_REQ'(1) << r_grant;
  assign w_req_g     = bus.req[r_grant];
  assign w_pop       = (r_state == BURST) && w_req_g && !bus.rd_empty;
  assign w_last_beat = w_pop && (r_beat == BEAT_W'(BURST_MAX - 1));

`ifdef FIFO_RD_ARB_WDOG_EN
  logic [STALL_W-1:0] r_stall;
  logic               w_stall;

  assign w_stall = (r_state == BURST) && w_req_g && bus.rd_empty;
  // Fires on the STALL_MAX-th consecutive stall cycle.
  assign w_wdog  = w_stall && (r_stall == STALL_W'(STALL_MAX - 1));

  // Anything other than a continuing stall (pop, drop, release, IDLE) clears the count.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_stall <= '0;
    end else if (w_stall && !w_wdog) begin
      r_stall <= r_stall + 1'b1;
    end else begin
      r_stall <= '0;
    end
  end
`else
  assign w_wdog = 1'b0;
`endif

  // A dropped request ends the burst in the same cycle without popping.
  assign w_end = (r_state == BURST) && (!w_req_g || w_last_beat || w_wdog);

  // FSM: state register
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_vld) w_state_nxt = BURST;
      BURST:   if (w_end)      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.gnt    = '0;
    bus.rd_ena = 1'b0;
    if (r_state == BURST) begin
      bus.gnt    = w_gnt_oh;
      bus.rd_ena = w_pop;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_grant     <= '0;
      r_last      <= IW'(NUM_REQ - 1);
      r_beat      <= '0;
      r_out_data  <= '0;
      r_out_valid <= '0;
    end else begin
      r_out_valid <= w_pop ? w_gnt_oh : '0;
      if (w_pop) begin
        r_out_data <= bus.rd_data;
      end
      if ((r_state == IDLE) && w_pick_vld) begin
        r_grant <= w_pick_idx;
        r_beat  <= '0;
      end else if (w_pop) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_end) begin
        r_last <= r_grant;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: directed bench for fifo_rd_arbiter with a simple FIFO read-side model.
// FIFO word at read index k is 8'hA0 + k; rd_empty is high when the model is drained or forced empty.
// Honours FIFO_RD_ARB_WDOG_EN for the empty-stall expectations.
module tb_fifo_rd_arbiter;
  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ptr    = 0;
  int   fill   = 0;
  logic force_empty = 1'b0;

  fifo_rd_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();

  fifo_rd_arbiter #(
    .ADDR_SIZE  (4),
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .BURST_MAX  (4),
    .STALL_MAX  (8)
  ) dut (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .bus    (bus.master)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd();
    bus.rd_empty = force_empty || (ptr >= fill);
    bus.rd_data  = 8'(32'hA0 + ptr);
    #1;
  endtask

  // Advance one clock; the model pops if rd_ena was high going into the edge.
  task automatic tick();
    logic p;
    p = bus.rd_ena;
    @(posedge rd_clk);
    #1;
    if (p && !rd_rst) ptr++;
    upd();
  endtask

  task automatic do_reset(input int new_fill);
    rd_rst      = 1'b1;
    bus.req     = '0;
    force_empty = 1'b0;
    ptr         = 0;
    fill        = new_fill;
    upd();
    tick();
    tick();
    rd_rst = 1'b0;
    upd();
  endtask

  initial begin
    logic [0:15] pat;
    logic [3:0]  exp_g;
    int          pulses;
    int          k;

    // ---------- reset state, single requester with 10 words ----------
    bus.req     = '0;
    fill        = 10;
    ptr         = 0;
    upd();
    tick();
    tick();
    chk("rst gnt",       32'(bus.gnt),       32'h0);
    chk("rst rd_ena",    32'(bus.rd_ena),    32'h0);
    chk("rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst out_data",  32'(bus.out_data),  32'h0);
    rd_rst = 1'b0;
    upd();

    // Bursts of 4, 4, 2 with one IDLE cycle between, then stalled on empty.
    pat     = 16'b0111_1011_1101_1000;
    bus.req = 4'b0001;
    upd();
    pulses = 0;
    k      = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t1 rd_ena c%0d", i), 32'(bus.rd_ena), 32'(pat[i]));
      if (i > 0 && pat[i-1]) begin
        chk($sformatf("t1 out_valid c%0d", i), 32'(bus.out_valid), 32'h1);
        chk($sformatf("t1 out_data c%0d", i), 32'(bus.out_data), 32'hA0 + 32'(k));
        k++;
      end else begin
        chk($sformatf("t1 out_valid c%0d", i), 32'(bus.out_valid), 32'h0);
      end
      if (bus.out_valid[0]) pulses++;
      tick();
    end
    chk("t1 pulse count", 32'(pulses), 32'd10);

    // ---------- two requesters, FIFO never empty ----------
    do_reset(1000);
    bus.req = 4'b1010;
    upd();
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 0)             exp_g = 4'b0000;
      else if ((i / 5) % 2 == 0)  exp_g = 4'b0010;
      else                        exp_g = 4'b1000;
      chk($sformatf("t2 gnt c%0d", i), 32'(bus.gnt), 32'(exp_g));
      tick();
    end

    // ---------- grant 2 drops its request after 2 pops ----------
    do_reset(1000);
    bus.req = 4'b0100;
    upd();
    chk("t3 gnt c0", 32'(bus.gnt), 32'h0);
    tick();
    chk("t3 gnt c1",    32'(bus.gnt),    32'h4);
    chk("t3 rd_ena c1", 32'(bus.rd_ena), 32'h1);
    tick();
    chk("t3 out_valid c2", 32'(bus.out_valid), 32'h4);
    chk("t3 out_data c2",  32'(bus.out_data),  32'hA0);
    tick();
    chk("t3 out_valid c3", 32'(bus.out_valid), 32'h4);
    chk("t3 out_data c3",  32'(bus.out_data),  32'hA1);
    bus.req = 4'b1011;
    #1;
    chk("t3 rd_ena drop", 32'(bus.rd_ena), 32'h0);
    chk("t3 gnt drop",    32'(bus.gnt),    32'h4);
    tick();
    chk("t3 gnt c4",       32'(bus.gnt),       32'h0);
    chk("t3 out_valid c4", 32'(bus.out_valid), 32'h0);
    tick();
    chk("t3 gnt c5", 32'(bus.gnt), 32'h8);
    tick();
    chk("t3 out_valid c6", 32'(bus.out_valid), 32'h8);
    chk("t3 out_data c6",  32'(bus.out_data),  32'hA2);
    for (int i = 0; i < 4; i++) tick();
    chk("t3 gnt c10", 32'(bus.gnt), 32'h1);
    for (int i = 0; i < 5; i++) tick();
    chk("t3 gnt c15", 32'(bus.gnt), 32'h2);

    // ---------- grant 0 with FIFO empty for 12 cycles ----------
    do_reset(1000);
    bus.req     = 4'b0001;
    force_empty = 1'b1;
    upd();
    for (int i = 1; i <= 12; i++) begin
      tick();
`ifdef FIFO_RD_ARB_WDOG_EN
      exp_g = (i == 9) ? 4'b0000 : 4'b0001;
`else
      exp_g = 4'b0001;
`endif
      chk($sformatf("t4 rd_ena c%0d", i), 32'(bus.rd_ena), 32'h0);
      chk($sformatf("t4 gnt c%0d", i),    32'(bus.gnt),    32'(exp_g));
    end
    force_empty = 1'b0;
    tick();
    chk("t4 rd_ena resume", 32'(bus.rd_ena), 32'h1);
    tick();
    chk("t4 out_valid resume", 32'(bus.out_valid), 32'h1);
    chk("t4 out_data resume",  32'(bus.out_data),  32'hA0);

    // ---------- reset in the middle of grant 1's burst ----------
    do_reset(1000);
    bus.req = 4'b0011;
    upd();
    for (int i = 0; i < 6; i++) tick();
    chk("t5 gnt c6", 32'(bus.gnt), 32'h2);
    tick();
    chk("t5 out_valid c7", 32'(bus.out_valid), 32'h2);
    chk("t5 out_data c7",  32'(bus.out_data),  32'hA4);
    rd_rst = 1'b1;
    #1;
    chk("t5 rst gnt",       32'(bus.gnt),       32'h0);
    chk("t5 rst rd_ena",    32'(bus.rd_ena),    32'h0);
    chk("t5 rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("t5 rst out_data",  32'(bus.out_data),  32'h0);
    tick();
    rd_rst = 1'b0;
    upd();
    chk("t5 idle gnt", 32'(bus.gnt), 32'h0);
    tick();
    chk("t5 first gnt", 32'(bus.gnt), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
